// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine sequencer: FSM states,
// register-file indices, constant-register init values and coin encodings.
package vend_pkg;

  typedef enum logic [3:0] {
    StInit0,
    StInit1,
    StInit2,
    StInit3,
    StInit4,
    StIdle,
    StAdd,
    StVend,
    StRefund
  } state_e;

  localparam logic [3:0] R_ONE    = 4'd0;
  localparam logic [3:0] R_TEN    = 4'd1;
  localparam logic [3:0] R_HUND   = 4'd2;
  localparam logic [3:0] R_SHIFT  = 4'd3;
  localparam logic [3:0] R_CREDIT = 4'd4;

  localparam logic [9:0] INIT_ONE   = 10'd1;
  localparam logic [9:0] INIT_TEN   = 10'd10;
  localparam logic [9:0] INIT_HUND  = 10'd100;
  localparam logic [9:0] INIT_SHIFT = 10'd4;

  localparam logic [1:0] COIN_ONE  = 2'b00;
  localparam logic [1:0] COIN_TEN  = 2'b01;
  localparam logic [1:0] COIN_HUND = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  // Constant register holding the value of a (valid) coin selection.
  function automatic logic [3:0] coin_reg(input logic [1:0] sel);
    unique case (sel)
      COIN_TEN:  coin_reg = R_TEN;
      COIN_HUND: coin_reg = R_HUND;
      default:   coin_reg = R_ONE;
    endcase
  endfunction

endpackage

// File: rtl/vend_ctrl.sv
// Vending sequencer: initialises the constant registers, then arbitrates coin,
// vend and cancel requests using the external register file for all credit math.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned MAX_CREDIT  = 1000,
  parameter int unsigned SCRATCH_REG = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_sel,
  input  logic       vend_req,
  input  logic [9:0] price,
  input  logic       cancel,
  output logic [3:0] rf_rw,
  output logic [3:0] rf_ra,
  output logic [3:0] rf_rb,
  output logic [9:0] rf_din,
  input  logic [9:0] rf_douta,
  input  logic [9:0] rf_doutb,
  output logic       ready,
  output logic       dispense,
  output logic       deny,
  output logic       coin_reject,
  output logic       refund_valid,
  output logic [9:0] change
);

  localparam logic [10:0] MaxCredit = 11'(MAX_CREDIT);
  localparam logic [3:0]  Scratch   = 4'(SCRATCH_REG);

  state_e      state;
  logic [1:0]  coin_sel_q;
  logic [9:0]  price_q;
  logic [10:0] sum;
  logic        add_ok;
  logic        vend_ok;

  // One extra bit so an over-limit sum is caught before anything is written.
  assign sum     = {1'b0, rf_douta} + {1'b0, rf_doutb};
  assign add_ok  = (sum <= MaxCredit);
  assign vend_ok = (rf_douta >= price_q);

  always_comb begin
    rf_rw  = Scratch;
    rf_ra  = R_CREDIT;
    rf_rb  = R_CREDIT;
    rf_din = '0;
    unique case (state)
      StInit0: begin rf_rw = R_ONE;    rf_din = INIT_ONE;   end
      StInit1: begin rf_rw = R_TEN;    rf_din = INIT_TEN;   end
      StInit2: begin rf_rw = R_HUND;   rf_din = INIT_HUND;  end
      StInit3: begin rf_rw = R_SHIFT;  rf_din = INIT_SHIFT; end
      StInit4: begin rf_rw = R_CREDIT; rf_din = '0;         end
      StAdd: begin
        rf_rb = coin_reg(coin_sel_q);
        if (add_ok) begin
          rf_rw  = R_CREDIT;
          rf_din = sum[9:0];
        end
      end
      StVend: begin
        if (vend_ok) rf_rw = R_CREDIT;
      end
      StRefund: rf_rw = R_CREDIT;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StInit0;
      ready        <= 1'b0;
      dispense     <= 1'b0;
      deny         <= 1'b0;
      coin_reject  <= 1'b0;
      refund_valid <= 1'b0;
      change       <= '0;
      coin_sel_q   <= '0;
      price_q      <= '0;
    end else begin
      dispense     <= 1'b0;
      deny         <= 1'b0;
      coin_reject  <= 1'b0;
      refund_valid <= 1'b0;
      unique case (state)
        StInit0: state <= StInit1;
        StInit1: state <= StInit2;
        StInit2: state <= StInit3;
        StInit3: state <= StInit4;
        StInit4: begin
          state <= StIdle;
          ready <= 1'b1;
        end
        StIdle: begin
          if (cancel) begin
            state <= StRefund;
            ready <= 1'b0;
          end else if (vend_req) begin
            price_q <= price;
            state   <= StVend;
            ready   <= 1'b0;
          end else if (coin_valid) begin
            if (coin_sel == COIN_BAD) begin
              coin_reject <= 1'b1;
            end else begin
              coin_sel_q <= coin_sel;
              state      <= StAdd;
              ready      <= 1'b0;
            end
          end
        end
        StAdd: begin
          coin_reject <= ~add_ok;
          state       <= StIdle;
          ready       <= 1'b1;
        end
        StVend: begin
          if (vend_ok) begin
            dispense     <= 1'b1;
            refund_valid <= 1'b1;
            change       <= rf_douta - price_q;
          end else begin
            deny <= 1'b1;
          end
          state <= StIdle;
          ready <= 1'b1;
        end
        StRefund: begin
          refund_valid <= 1'b1;
          change       <= rf_douta;
          state        <= StIdle;
          ready        <= 1'b1;
        end
        default: begin
          state <= StInit0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl with a behavioural 16x10 register file.
module tb_vend_ctrl;

  logic       clk;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       vend_req;
  logic [9:0] price;
  logic       cancel;
  logic [3:0] rf_rw, rf_ra, rf_rb;
  logic [9:0] rf_din, rf_douta, rf_doutb;
  logic       ready, dispense, deny, coin_reject, refund_valid;
  logic [9:0] change;

  int checks = 0;
  int errors = 0;
  int bad_writes = 0;

  logic [9:0] rf [16];

  vend_ctrl #(
    .MAX_CREDIT (1000),
    .SCRATCH_REG(15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_valid  (coin_valid),
    .coin_sel    (coin_sel),
    .vend_req    (vend_req),
    .price       (price),
    .cancel      (cancel),
    .rf_rw       (rf_rw),
    .rf_ra       (rf_ra),
    .rf_rb       (rf_rb),
    .rf_din      (rf_din),
    .rf_douta    (rf_douta),
    .rf_doutb    (rf_doutb),
    .ready       (ready),
    .dispense    (dispense),
    .deny        (deny),
    .coin_reject (coin_reject),
    .refund_valid(refund_valid),
    .change      (change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: writes every clock, combinational reads.
  initial for (int i = 0; i < 16; i++) rf[i] = 10'h2aa;
  always @(posedge clk) begin
    rf[rf_rw] <= rf_din;
    if (rf_rw >= 4'd5 && rf_rw <= 4'd14) bad_writes++;
  end
  assign rf_douta = rf[rf_ra];
  assign rf_doutb = rf[rf_rb];

  typedef struct {
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       vend_req;
    logic [9:0] price;
    logic       cancel;
    logic       one_cycle;
    logic [3:0] exp_pulse;   // {dispense, deny, coin_reject, refund_valid}
    logic [9:0] exp_change;
    logic [9:0] exp_r4;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t coin_vec(input logic [1:0] sel, input logic [9:0] r4,
                                    input logic [9:0] chg, input logic rej);
    vec_t v;
    v = '{1'b1, sel, 1'b0, 10'd0, 1'b0, (sel == 2'b11), {2'b00, rej, 1'b0}, chg, r4};
    return v;
  endfunction

  task automatic clear_inputs();
    coin_valid = 1'b0;
    coin_sel   = 2'b00;
    vend_req   = 1'b0;
    price      = '0;
    cancel     = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    chk($sformatf("%s ready_before", name), int'(ready), 1);
    coin_valid = v.coin_valid;
    coin_sel   = v.coin_sel;
    vend_req   = v.vend_req;
    price      = v.price;
    cancel     = v.cancel;
    @(posedge clk);
    #1;
    clear_inputs();
    if (!v.one_cycle) begin
      chk($sformatf("%s ready_busy", name), int'(ready), 0);
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s pulses", name),
        int'({dispense, deny, coin_reject, refund_valid}), int'(v.exp_pulse));
    chk($sformatf("%s change", name), int'(change), int'(v.exp_change));
    chk($sformatf("%s r4", name), int'(rf[4]), int'(v.exp_r4));
    chk($sformatf("%s ready_after", name), int'(ready), 1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk($sformatf("%s ready", name), int'(ready), 0);
    chk($sformatf("%s pulses", name),
        int'({dispense, deny, coin_reject, refund_valid}), 0);
    chk($sformatf("%s change", name), int'(change), 0);
  endtask

  task automatic init_sequence(input string name);
    repeat (2) @(negedge clk);
    check_reset_outputs($sformatf("%s in_reset", name));
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s ready_edge%0d", name, e), int'(ready), (e == 5) ? 1 : 0);
    end
    chk($sformatf("%s r0", name), int'(rf[0]), 1);
    chk($sformatf("%s r1", name), int'(rf[1]), 10);
    chk($sformatf("%s r2", name), int'(rf[2]), 100);
    chk($sformatf("%s r3", name), int'(rf[3]), 4);
    chk($sformatf("%s r4", name), int'(rf[4]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [9:0] r4;
    rst_n = 1'b0;
    clear_inputs();

    vecs[0] = coin_vec(2'b10, 10'd100, 10'd0, 1'b0);
    vecs[1] = coin_vec(2'b10, 10'd200, 10'd0, 1'b0);
    vecs[2] = coin_vec(2'b01, 10'd210, 10'd0, 1'b0);
    vecs[3] = coin_vec(2'b00, 10'd211, 10'd0, 1'b0);
    vecs[4] = '{1'b0, 2'b00, 1'b1, 10'd150, 1'b0, 1'b0, 4'b1001, 10'd61, 10'd0};
    vecs[5] = coin_vec(2'b10, 10'd100, 10'd61, 1'b0);
    vecs[6] = '{1'b0, 2'b00, 1'b1, 10'd150, 1'b0, 1'b0, 4'b0100, 10'd61, 10'd100};
    vecs[7] = '{1'b1, 2'b00, 1'b1, 10'd50, 1'b1, 1'b0, 4'b0001, 10'd100, 10'd0};
    vecs[8] = coin_vec(2'b11, 10'd0, 10'd100, 1'b1);
    vecs[9] = '{1'b0, 2'b00, 1'b0, 10'd0, 1'b1, 1'b0, 4'b0001, 10'd0, 10'd0};

    init_sequence("init");

    for (int i = 0; i < 10; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Build credit up to 995, then probe the MAX_CREDIT boundary.
    r4 = 10'd0;
    for (int i = 0; i < 9; i++) begin
      r4 = r4 + 10'd100;
      apply(coin_vec(2'b10, r4, 10'd0, 1'b0), $sformatf("fill100_%0d", i));
    end
    for (int i = 0; i < 9; i++) begin
      r4 = r4 + 10'd10;
      apply(coin_vec(2'b01, r4, 10'd0, 1'b0), $sformatf("fill10_%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      r4 = r4 + 10'd1;
      apply(coin_vec(2'b00, r4, 10'd0, 1'b0), $sformatf("fill1_%0d", i));
    end
    apply(coin_vec(2'b01, 10'd995, 10'd0, 1'b1), "over_995_plus_10");
    for (int i = 0; i < 5; i++) begin
      r4 = r4 + 10'd1;
      apply(coin_vec(2'b00, r4, 10'd0, 1'b0), $sformatf("top1_%0d", i));
    end
    apply(coin_vec(2'b00, 10'd1000, 10'd0, 1'b1), "over_1000_plus_1");
    v = '{1'b0, 2'b00, 1'b1, 10'd1000, 1'b0, 1'b0, 4'b1001, 10'd0, 10'd0};
    apply(v, "vend_exact_1000");

    // Coin held high through the busy cycle must count once.
    @(negedge clk);
    coin_valid = 1'b1;
    coin_sel   = 2'b10;
    @(posedge clk);
    #1;
    chk("held_coin ready_busy", int'(ready), 0);
    @(posedge clk);
    #1;
    clear_inputs();
    chk("held_coin r4", int'(rf[4]), 100);
    chk("held_coin ready", int'(ready), 1);
    @(posedge clk);
    #1;
    chk("held_coin r4_stable", int'(rf[4]), 100);

    v = '{1'b0, 2'b00, 1'b1, 10'd30, 1'b0, 1'b0, 4'b1001, 10'd70, 10'd0};
    apply(v, "vend_30");
    apply(coin_vec(2'b10, 10'd100, 10'd70, 1'b0), "pre_reset_coin");

    // Reset asserted while an ADD is in flight.
    @(negedge clk);
    coin_valid = 1'b1;
    coin_sel   = 2'b01;
    @(posedge clk);
    #1;
    clear_inputs();
    chk("mid_add ready", int'(ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_add async");
    init_sequence("replay");

    chk("no_writes_r5_r14", bad_writes, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
